// File: rtl/leading_normalizer.sv
// leading_normalizer: two-stage valid/ready pipeline that strips the run of
// leading BIT-valued bits from each word by shifting it left, refilling the
// vacated LSBs with BIT, and reports how many bits were removed.
// Stage 1 registers the word together with its leading-run count; stage 2
// holds the shifted result on the output ports.
module leading_normalizer #(
  parameter int   WIDTH       = 12,
  parameter logic BIT         = 1'b0,
  parameter int   COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [WIDTH-1:0]       inVector,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [WIDTH-1:0]       outVector,
  output logic [COUNT_WIDTH-1:0] outShift,
  output logic                   outAllLeading
);

  // Number of consecutive BIT-valued bits starting at the MSB (WIDTH if all).
  function automatic logic [COUNT_WIDTH-1:0] lead_count(input logic [WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] c;
    logic                   run;
    c   = '0;
    run = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (run && (v[i] == BIT)) begin
        c = c + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return c;
  endfunction

  logic                   s1_valid_r;
  logic [WIDTH-1:0]       s1_vector_r;
  logic [COUNT_WIDTH-1:0] s1_count_r;
  logic                   s2_load_s;
  logic [WIDTH-1:0]       shifted_s;
  logic [WIDTH-1:0]       fill_s;
  logic [WIDTH-1:0]       next_vector_s;

  // Stage 2 can take a word when it is empty or its word leaves this edge;
  // stage 1 drains on the same condition, so inReady never looks at inValid.
  assign s2_load_s = !outValid || outReady;
  assign inReady   = !s1_valid_r || s2_load_s;

  // Left shift by the stage-1 count with the vacated LSBs filled with BIT;
  // a shift by WIDTH produces an all-fill word.
  always_comb begin
    shifted_s = s1_vector_r << s1_count_r;
    if (BIT == 1'b1) begin
      fill_s = ~({WIDTH{1'b1}} << s1_count_r);
    end else begin
      fill_s = '0;
    end
    next_vector_s = shifted_s | fill_s;
  end

  // Stage 1: capture the accepted word and its leading-run count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      s1_vector_r <= '0;
      s1_count_r  <= '0;
    end else if (inReady) begin
      s1_valid_r <= inValid;
      if (inValid) begin
        s1_vector_r <= inVector;
        s1_count_r  <= lead_count(inVector);
      end
    end
  end

  // Stage 2: registered outputs, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid      <= 1'b0;
      outVector     <= '0;
      outShift      <= '0;
      outAllLeading <= 1'b0;
    end else if (s2_load_s) begin
      outValid <= s1_valid_r;
      if (s1_valid_r) begin
        outVector     <= next_vector_s;
        outShift      <= s1_count_r;
        outAllLeading <= (s1_count_r == COUNT_WIDTH'(WIDTH));
      end
    end
  end

endmodule

// File: tb/tb_leading_normalizer.sv
// Directed bench for leading_normalizer: a zeros-mode instance exercised for
// latency, boundaries, backpressure, throughput and reset, plus a ones-mode
// instance for the BIT=1 cases.
module tb_leading_normalizer;

  logic        clk;
  logic        reset;
  logic        inValid, inReady, outValid, outReady, outAllLeading;
  logic [11:0] inVector, outVector;
  logic [3:0]  outShift;
  logic        i1Valid, i1Ready, o1Valid, o1Ready, o1All;
  logic [11:0] i1Vector, o1Vector;
  logic [3:0]  o1Shift;

  int vectors = 0;
  int miscompares = 0;
  int popped = 0;
  logic [16:0] sb[$];

  leading_normalizer #(.WIDTH(12), .BIT(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady), .inVector(inVector),
    .outValid(outValid), .outReady(outReady), .outVector(outVector),
    .outShift(outShift), .outAllLeading(outAllLeading)
  );

  leading_normalizer #(.WIDTH(12), .BIT(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .inValid(i1Valid), .inReady(i1Ready), .inVector(i1Vector),
    .outValid(o1Valid), .outReady(o1Ready), .outVector(o1Vector),
    .outShift(o1Shift), .outAllLeading(o1All)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: shift one bit at a time while the MSB equals b.
  function automatic logic [16:0] model(input logic [11:0] v, input logic b);
    logic [11:0] t;
    int n;
    t = v;
    n = 0;
    while (n < 12 && t[11] == b) begin
      t = {t[10:0], b};
      n++;
    end
    return {(n == 12), 4'(n), t};
  endfunction

  // One clock: scoreboard at the falling edge, then return 1 time unit after the rising edge.
  task automatic cycle();
    logic [16:0] e;
    @(negedge clk);
    if (outValid && outReady) begin
      if (sb.size() == 0) begin
        check("sb_extra_out", {31'd0, outValid}, 32'd0);
      end else begin
        e = sb.pop_front();
        popped++;
        check("sb_vector", {20'd0, outVector}, {20'd0, e[11:0]});
        check("sb_shift", {28'd0, outShift}, {28'd0, e[15:12]});
        check("sb_all", {31'd0, outAllLeading}, {31'd0, e[16]});
      end
    end
    if (inValid && inReady) sb.push_back(model(inVector, 1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [11:0] v, input logic [11:0] ev,
                          input logic [3:0] es, input logic ea);
    inValid = 1'b1;
    inVector = v;
    outReady = 1'b1;
    cycle();
    inValid = 1'b0;
    check("lat_first_edge", {31'd0, outValid}, 32'd0);
    cycle();
    check("lat_valid", {31'd0, outValid}, 32'd1);
    check("one_vector", {20'd0, outVector}, {20'd0, ev});
    check("one_shift", {28'd0, outShift}, {28'd0, es});
    check("one_all", {31'd0, outAllLeading}, {31'd0, ea});
    cycle();
    check("one_drained", {31'd0, outValid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    inValid = 1'b0; inVector = 12'h000; outReady = 1'b0;
    i1Valid = 1'b0; i1Vector = 12'h000; o1Ready = 1'b0;
    #12;
    check("rst_valid", {31'd0, outValid}, 32'd0);
    check("rst_vector", {20'd0, outVector}, 32'd0);
    check("rst_shift", {28'd0, outShift}, 32'd0);
    check("rst_all", {31'd0, outAllLeading}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_inready", {31'd0, inReady}, 32'd1);
    check("rst_inready1", {31'd0, i1Ready}, 32'd1);

    // Zeros mode: main case and boundaries.
    send_one(12'h0F0, 12'hF00, 4'd4, 1'b0);
    send_one(12'h800, 12'h800, 4'd0, 1'b0);
    send_one(12'h001, 12'h800, 4'd11, 1'b0);
    send_one(12'h000, 12'h000, 4'd12, 1'b1);

    // Ones mode.
    i1Valid = 1'b1; i1Vector = 12'hF0F; o1Ready = 1'b1;
    cycle();
    i1Vector = 12'hFFF;
    cycle();
    i1Valid = 1'b0;
    check("ones_valid", {31'd0, o1Valid}, 32'd1);
    check("ones_vector", {20'd0, o1Vector}, 32'h0FF);
    check("ones_shift", {28'd0, o1Shift}, 32'd4);
    check("ones_all", {31'd0, o1All}, 32'd0);
    cycle();
    check("ones_full_vector", {20'd0, o1Vector}, 32'hFFF);
    check("ones_full_shift", {28'd0, o1Shift}, 32'd12);
    check("ones_full_all", {31'd0, o1All}, 32'd1);
    cycle();
    check("ones_drained", {31'd0, o1Valid}, 32'd0);

    // Backpressure: two words buffer, then inReady drops and outputs hold.
    outReady = 1'b0;
    inValid = 1'b1; inVector = 12'h100;
    cycle();
    inVector = 12'h020;
    cycle();
    inVector = 12'h003;
    check("bp_inready_low", {31'd0, inReady}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("bp_inready_hold", {31'd0, inReady}, 32'd0);
      check("bp_valid_hold", {31'd0, outValid}, 32'd1);
      check("bp_shift_hold", {28'd0, outShift}, 32'd3);
      check("bp_vector_hold", {20'd0, outVector}, 32'h800);
    end
    outReady = 1'b1;
    cycle();
    check("bp_out2", {28'd0, outShift}, 32'd6);
    inVector = 12'h400;
    cycle();
    check("bp_out3", {28'd0, outShift}, 32'd10);
    inValid = 1'b0;
    cycle();
    check("bp_out4", {28'd0, outShift}, 32'd1);
    check("bp_out4_valid", {31'd0, outValid}, 32'd1);
    cycle();
    check("bp_empty", {31'd0, outValid}, 32'd0);
    check("bp_sb_empty", sb.size(), 32'd0);

    // Full throughput: 16 back-to-back words.
    popped = 0;
    inValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inVector = 12'($urandom_range(0, 4095) >> $urandom_range(0, 12));
      cycle();
      check("tp_valid", {31'd0, outValid}, (i == 0) ? 32'd0 : 32'd1);
    end
    inValid = 1'b0;
    cycle();
    check("tp_last_valid", {31'd0, outValid}, 32'd1);
    cycle();
    check("tp_end_valid", {31'd0, outValid}, 32'd0);
    check("tp_count", popped, 32'd16);

    // Reset mid-operation with two words in flight.
    outReady = 1'b0;
    inValid = 1'b1; inVector = 12'h0F0;
    cycle();
    inVector = 12'h001;
    cycle();
    inValid = 1'b0;
    check("mid_inflight", {31'd0, outValid}, 32'd1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_valid", {31'd0, outValid}, 32'd0);
    check("mid_rst_shift", {28'd0, outShift}, 32'd0);
    check("mid_rst_vector", {20'd0, outVector}, 32'd0);
    cycle();
    #3;
    reset = 1'b0;
    cycle();
    check("mid_inready", {31'd0, inReady}, 32'd1);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("mid_no_stale", {31'd0, outValid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
